// File: rtl/led_frame_recv.sv
// Receive side of the APA102-style LED link: oversampled clock/data, start/LED/end frame decode.
// Optional macro LED_FRAME_RECV_STATS_EN adds good/error packet counters.
module led_frame_recv #(
    parameter int LED_NUM     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CNT = 1024
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_en,
    input  logic       cki,
    input  logic       sdi,
    output logic       pix_valid,
    output logic [7:0] pix_idx,
    output logic [4:0] pix_bright,
    output logic [7:0] pix_blue,
    output logic [7:0] pix_green,
    output logic [7:0] pix_red,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy
`ifdef LED_FRAME_RECV_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [15:0] stat_good,
    output logic [15:0] stat_err
`endif
);

    localparam logic [1:0]  HUNT     = 2'd0;
    localparam logic [1:0]  SYNC     = 2'd1;
    localparam logic [1:0]  FRAME    = 2'd2;
    localparam logic [7:0]  LED_LAST = 8'(LED_NUM);
    localparam logic [15:0] TO_LIM   = 16'(TIMEOUT_CNT);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [5:0] sat_inc_zrun(input logic [5:0] v);
        return (v >= 6'd32) ? 6'd32 : v + 6'd1;
    endfunction

    logic [SYNC_STAGES-1:0] cki_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   cki_d;
    logic                   rise;
    logic                   bit_in;
    logic                   timed_out;

    logic [1:0]  state;
    logic [5:0]  zrun;
    logic [5:0]  bcnt;
    logic [7:0]  led_cnt;
    logic [15:0] tcnt;
    logic [31:0] sh;
    logic        rdy_p0;
    logic        pix_p1;
    logic        done_p1;
    logic        err_p1;
    logic [1:0]  code_p1;
    logic [28:0] word_p1;
    logic [7:0]  idx_p1;

    assign rise      = cki_sync[SYNC_STAGES-1] & ~cki_d;
    assign bit_in    = sdi_sync[SYNC_STAGES-1];
    assign timed_out = (tcnt >= TO_LIM);
    assign busy      = (state != HUNT);

    // input synchronisers; idle link looks like clock low, data high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cki_sync <= '0;
            sdi_sync <= '1;
            cki_d    <= 1'b0;
        end else begin
            cki_sync <= {cki_sync[SYNC_STAGES-2:0], cki};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            cki_d    <= cki_sync[SYNC_STAGES-1];
        end
    end

    // stage p0: bit capture and frame FSM; a completed word is judged one cycle after its last bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= HUNT;
            zrun    <= '0;
            bcnt    <= '0;
            led_cnt <= '0;
            tcnt    <= '0;
            rdy_p0  <= 1'b0;
            pix_p1  <= 1'b0;
            done_p1 <= 1'b0;
            err_p1  <= 1'b0;
            code_p1 <= '0;
        end else if (!rx_en) begin
            state   <= HUNT;
            zrun    <= '0;
            bcnt    <= '0;
            led_cnt <= '0;
            tcnt    <= '0;
            rdy_p0  <= 1'b0;
            pix_p1  <= 1'b0;
            done_p1 <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            rdy_p0  <= 1'b0;
            pix_p1  <= 1'b0;
            done_p1 <= 1'b0;
            err_p1  <= 1'b0;
            tcnt    <= rise ? 16'd0 : sat_inc16(tcnt);
            case (state)
                HUNT: begin
                    if (zrun == 6'd32) begin
                        state <= SYNC;
                    end else if (rise) begin
                        zrun <= bit_in ? 6'd0 : sat_inc_zrun(zrun);
                    end else if (timed_out) begin
                        zrun <= '0;
                    end
                end
                SYNC: begin
                    if (rise && bit_in) begin
                        bcnt    <= 6'd1;
                        led_cnt <= '0;
                        state   <= FRAME;
                    end else if (!rise && timed_out) begin
                        err_p1  <= 1'b1;
                        code_p1 <= 2'd3;
                        state   <= HUNT;
                        zrun    <= '0;
                    end
                end
                FRAME: begin
                    if (rise) begin
                        bcnt   <= bcnt + 6'd1;
                        rdy_p0 <= (bcnt == 6'd31);
                    end else if (rdy_p0) begin
                        bcnt <= '0;
                        if (led_cnt < LED_LAST) begin
                            if (sh[31:29] == 3'b111) begin
                                pix_p1  <= 1'b1;
                                led_cnt <= led_cnt + 8'd1;
                            end else begin
                                err_p1  <= 1'b1;
                                code_p1 <= 2'd1;
                                state   <= HUNT;
                                zrun    <= '0;
                            end
                        end else begin
                            if (sh == 32'hFFFF_FFFF) begin
                                done_p1 <= 1'b1;
                            end else begin
                                err_p1  <= 1'b1;
                                code_p1 <= 2'd2;
                            end
                            state <= HUNT;
                            zrun  <= '0;
                        end
                    end else if (timed_out) begin
                        err_p1  <= 1'b1;
                        code_p1 <= 2'd3;
                        state   <= HUNT;
                        zrun    <= '0;
                    end
                end
                default: begin
                    state <= HUNT;
                    zrun  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rise && (state == SYNC) && bit_in) begin
            sh <= 32'd1;
        end else if (rise && (state == FRAME)) begin
            sh <= {sh[30:0], bit_in};
        end
        if (rdy_p0) begin
            word_p1 <= sh[28:0];
            idx_p1  <= led_cnt;
        end
    end

    // stage p1 -> outputs; pixel fields and error code hold until their next strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_valid  <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_err    <= 1'b0;
            err_code   <= '0;
            pix_idx    <= '0;
            pix_bright <= '0;
            pix_blue   <= '0;
            pix_green  <= '0;
            pix_red    <= '0;
        end else begin
            pix_valid <= pix_p1 & rx_en;
            pkt_done  <= done_p1 & rx_en;
            pkt_err   <= err_p1 & rx_en;
            if (err_p1 && rx_en) begin
                err_code <= code_p1;
            end
            if (pix_p1 && rx_en) begin
                pix_idx    <= idx_p1;
                pix_bright <= word_p1[28:24];
                pix_blue   <= word_p1[23:16];
                pix_green  <= word_p1[15:8];
                pix_red    <= word_p1[7:0];
            end
        end
    end

`ifdef LED_FRAME_RECV_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_good <= '0;
            stat_err  <= '0;
        end else if (stat_clr) begin
            stat_good <= '0;
            stat_err  <= '0;
        end else begin
            if (pkt_done) begin
                stat_good <= sat_inc16(stat_good);
            end
            if (pkt_err) begin
                stat_err <= sat_inc16(stat_err);
            end
        end
    end
`endif

endmodule

// File: tb/tb_led_frame_recv.sv
// Self-checking bench for led_frame_recv: scoreboard of expected pixel/done/error events.
`timescale 1ns/1ps
module tb_led_frame_recv;

    localparam int      LED_NUM   = 4;
    localparam realtime CLK_HALF  = 3.333;
    localparam realtime LINK_HALF = 16.667;

    localparam logic [1:0] EV_PIX  = 2'd0;
    localparam logic [1:0] EV_DONE = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  idx;
        logic [28:0] word;
        logic [1:0]  code;
    } ev_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_en = 1'b1;
    logic       cki = 1'b0;
    logic       sdi = 1'b1;
    logic       pix_valid;
    logic [7:0] pix_idx;
    logic [4:0] pix_bright;
    logic [7:0] pix_blue;
    logic [7:0] pix_green;
    logic [7:0] pix_red;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;
`ifdef LED_FRAME_RECV_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_good;
    logic [15:0] stat_err;
`endif

    ev_t         exp_q[$];
    ev_t         obs_ev;
    ev_t         exp_ev;
    int          compared = 0;
    int          mismatched = 0;
    int          strobes = 0;
    logic [1:0]  exp_code = 2'd0;
    logic [31:0] pkt_w [LED_NUM];

    always #CLK_HALF clk = ~clk;

    led_frame_recv #(.LED_NUM(LED_NUM), .SYNC_STAGES(2), .TIMEOUT_CNT(1024)) dut (
        .clk(clk), .rstn(rstn), .rx_en(rx_en), .cki(cki), .sdi(sdi),
        .pix_valid(pix_valid), .pix_idx(pix_idx), .pix_bright(pix_bright),
        .pix_blue(pix_blue), .pix_green(pix_green), .pix_red(pix_red),
        .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code), .busy(busy)
`ifdef LED_FRAME_RECV_STATS_EN
        , .stat_clr(stat_clr), .stat_good(stat_good), .stat_err(stat_err)
`endif
    );

    // Scoreboard: every strobe pops the oldest expected event
    always @(negedge clk) begin
        if (pix_valid || pkt_done || pkt_err) begin
            strobes++;
            compared++;
            if ((32'(pix_valid) + 32'(pkt_done) + 32'(pkt_err)) != 1) begin
                mismatched++;
                $display("FAIL strobe_excl: got pix/done/err=%b%b%b, need exactly one", pix_valid, pkt_done, pkt_err);
            end
            obs_ev = '0;
            if (pix_valid) begin
                obs_ev.kind = EV_PIX;
                obs_ev.idx  = pix_idx;
                obs_ev.word = {pix_bright, pix_blue, pix_green, pix_red};
            end else if (pkt_done) begin
                obs_ev.kind = EV_DONE;
            end else begin
                obs_ev.kind = EV_ERR;
                obs_ev.code = err_code;
            end
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event: got %h, expected none at %0t", obs_ev, $time);
            end else begin
                exp_ev = exp_q.pop_front();
                if (obs_ev !== exp_ev) begin
                    mismatched++;
                    $display("FAIL event: got %h expected %h at %0t", obs_ev, exp_ev, $time);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_ev(input logic [1:0] kind, input logic [7:0] idx,
                           input logic [28:0] word, input logic [1:0] code);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.word = word;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        cki = 1'b0;
        sdi = b;
        #LINK_HALF;
        cki = 1'b1;
        #LINK_HALF;
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[31-i]);
    endtask

    task automatic load_default();
        pkt_w[0] = 32'hE101_0203;
        pkt_w[1] = 32'hFF00_00FF;
        pkt_w[2] = 32'hE0FF_FFFF;
        pkt_w[3] = 32'hFFFF_FFFF;
    endtask

    // Drives a full packet and records the events the receiver should produce
    task automatic send_pkt(input int nz, input logic [31:0] end_w);
        bit alive;
        alive = (nz >= 32);
        for (int i = 0; i < nz; i++) send_bit(1'b0);
        for (int i = 0; i < LED_NUM; i++) begin
            if (alive) begin
                if (pkt_w[i][31:29] == 3'b111) begin
                    push_ev(EV_PIX, 8'(i), pkt_w[i][28:0], 2'd0);
                end else begin
                    push_ev(EV_ERR, 8'd0, 29'd0, 2'd1);
                    exp_code = 2'd1;
                    alive = 1'b0;
                end
            end
            send_word(pkt_w[i], 32);
        end
        if (alive) begin
            if (end_w == 32'hFFFF_FFFF) begin
                push_ev(EV_DONE, 8'd0, 29'd0, 2'd0);
            end else begin
                push_ev(EV_ERR, 8'd0, 29'd0, 2'd2);
                exp_code = 2'd2;
            end
        end
        send_word(end_w, 32);
        send_word(32'hFFFF_FFFF, 32);
        cki = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        compared++;
        if ({pix_valid, pkt_done, pkt_err, busy} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_strobes: got %b required 0000", {pix_valid, pkt_done, pkt_err, busy});
        end
        compared++;
        if ({pix_idx, pix_bright, pix_blue, pix_green, pix_red, err_code} !== 39'd0) begin
            mismatched++;
            $display("FAIL reset_fields: got %h required 0", {pix_idx, pix_bright, pix_blue, pix_green, pix_red, err_code});
        end
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_good_packet();
        int s0;
        load_default();
        s0 = strobes;
        send_pkt(32, 32'hFFFF_FFFF);
        wait_drain();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL good_pending: got %0d events outstanding required 0", exp_q.size());
        end
        compared++;
        if (strobes - s0 != 5) begin
            mismatched++;
            $display("FAIL good_strobes: got %0d required 5", strobes - s0);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL good_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_bad_header();
        int s0;
        load_default();
        pkt_w[2] = 32'h7F00_FF00;
        s0 = strobes;
        send_pkt(32, 32'hFFFF_FFFF);
        wait_drain();
        compared++;
        if (exp_q.size() != 0 || strobes - s0 != 3) begin
            mismatched++;
            $display("FAIL hdr_events: got %0d strobes %0d pending, required 3 strobes 0 pending", strobes - s0, exp_q.size());
        end
        compared++;
        if (err_code !== 2'd1) begin
            mismatched++;
            $display("FAIL hdr_code: got %0d required 1", err_code);
        end
        load_default();
        s0 = strobes;
        send_pkt(32, 32'hFFFF_FFFF);
        wait_drain();
        compared++;
        if (exp_q.size() != 0 || strobes - s0 != 5) begin
            mismatched++;
            $display("FAIL hdr_recover: got %0d strobes %0d pending, required 5 strobes 0 pending", strobes - s0, exp_q.size());
        end
    endtask

    task automatic test_bad_end();
        int s0;
        load_default();
        s0 = strobes;
        send_pkt(32, 32'hFFFF_FFFE);
        wait_drain();
        compared++;
        if (exp_q.size() != 0 || strobes - s0 != 5) begin
            mismatched++;
            $display("FAIL end_events: got %0d strobes %0d pending, required 5 strobes 0 pending", strobes - s0, exp_q.size());
        end
        compared++;
        if (err_code !== 2'd2) begin
            mismatched++;
            $display("FAIL end_code: got %0d required 2", err_code);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 32; i++) send_bit(1'b0);
        push_ev(EV_ERR, 8'd0, 29'd0, 2'd3);
        exp_code = 2'd3;
        send_word(32'hE101_0203, 10);
        cki = 1'b0;
        repeat (4) @(negedge clk);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL to_busy_mid: got %b required 1", busy);
        end
        repeat (1100) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL to_pending: got %0d events outstanding required 0", exp_q.size());
        end
        compared++;
        if (err_code !== 2'd3 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL to_state: got code %0d busy %b required code 3 busy 0", err_code, busy);
        end
    endtask

    task automatic test_start_len();
        int s0;
        load_default();
        s0 = strobes;
        send_pkt(40, 32'hFFFF_FFFF);
        wait_drain();
        compared++;
        if (exp_q.size() != 0 || strobes - s0 != 5) begin
            mismatched++;
            $display("FAIL long_start: got %0d strobes %0d pending, required 5 strobes 0 pending", strobes - s0, exp_q.size());
        end
        s0 = strobes;
        send_pkt(31, 32'hFFFF_FFFF);
        repeat (50) @(negedge clk);
        compared++;
        if (strobes - s0 != 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL short_start: got %0d strobes busy %b, required 0 strobes busy 0", strobes - s0, busy);
        end
    endtask

    task automatic test_rx_en();
        int s0;
        load_default();
        s0 = strobes;
        for (int i = 0; i < 32; i++) send_bit(1'b0);
        push_ev(EV_PIX, 8'd0, pkt_w[0][28:0], 2'd0);
        send_word(pkt_w[0], 32);
        send_word(pkt_w[1], 10);
        @(negedge clk);
        rx_en = 1'b0;
        repeat (5) @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rxen_busy: got %b required 0", busy);
        end
        rx_en = 1'b1;
        cki = 1'b0;
        repeat (40) @(negedge clk);
        compared++;
        if (err_code !== exp_code || strobes - s0 != 1 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL rxen_silent: got code %0d strobes %0d pending %0d, required code %0d strobes 1 pending 0",
                     err_code, strobes - s0, exp_q.size(), exp_code);
        end
        s0 = strobes;
        send_pkt(32, 32'hFFFF_FFFF);
        wait_drain();
        compared++;
        if (exp_q.size() != 0 || strobes - s0 != 5) begin
            mismatched++;
            $display("FAIL rxen_recover: got %0d strobes %0d pending, required 5 strobes 0 pending", strobes - s0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_stats();
        load_default();
        for (int i = 0; i < 32; i++) send_bit(1'b0);
        push_ev(EV_PIX, 8'd0, pkt_w[0][28:0], 2'd0);
        send_word(pkt_w[0], 32);
        send_word(pkt_w[1], 16);
        @(negedge clk);
        rstn = 1'b0;
        cki = 1'b0;
        #1;
        exp_code = 2'd0;
        compared++;
        if ({pix_valid, pkt_done, pkt_err, busy, err_code} !== 6'd0) begin
            mismatched++;
            $display("FAIL midrst_ctrl: got %b required 000000", {pix_valid, pkt_done, pkt_err, busy, err_code});
        end
        compared++;
        if ({pix_idx, pix_bright, pix_blue, pix_green, pix_red} !== 37'd0) begin
            mismatched++;
            $display("FAIL midrst_fields: got %h required 0", {pix_idx, pix_bright, pix_blue, pix_green, pix_red});
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL midrst_pending: got %0d required 0", exp_q.size());
        end
        for (int p = 0; p < 3; p++) send_pkt(32, 32'hFFFF_FFFF);
        send_pkt(32, 32'h0000_0000);
        wait_drain();
        compared++;
        if (exp_q.size() != 0 || err_code !== 2'd2) begin
            mismatched++;
            $display("FAIL stats_pkts: got pending %0d code %0d required 0 and 2", exp_q.size(), err_code);
        end
`ifdef LED_FRAME_RECV_STATS_EN
        compared++;
        if (stat_good !== 16'd3 || stat_err !== 16'd1) begin
            mismatched++;
            $display("FAIL stats_count: got good %0d err %0d required 3 and 1", stat_good, stat_err);
        end
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        @(negedge clk);
        compared++;
        if (stat_good !== 16'd0 || stat_err !== 16'd0) begin
            mismatched++;
            $display("FAIL stats_clr: got good %0d err %0d required 0 and 0", stat_good, stat_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_header();
        test_bad_end();
        test_timeout();
        test_start_len();
        test_rx_en();
        test_reset_mid_stats();
        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
